// File: rtl/bf_defs.sv
// Shared definitions for the BF code loader and core: FSM states, opcode bytes,
// terminator value and load-error codes.
package bf_defs;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2,
    StError = 2'd3
  } state_e;

  localparam logic [7:0] OpInc   = 8'h2B;
  localparam logic [7:0] OpDec   = 8'h2D;
  localparam logic [7:0] OpLeft  = 8'h3C;
  localparam logic [7:0] OpRight = 8'h3E;
  localparam logic [7:0] OpOpen  = 8'h5B;
  localparam logic [7:0] OpClose = 8'h5D;
  localparam logic [7:0] OpOut   = 8'h2E;
  localparam logic [7:0] OpIn    = 8'h2C;
  localparam logic [7:0] Term    = 8'h00;

  localparam logic [1:0] ErrNone           = 2'b00;
  localparam logic [1:0] ErrUnmatchedClose = 2'b01;
  localparam logic [1:0] ErrUnmatchedOpen  = 2'b10;
  localparam logic [1:0] ErrOverflow       = 2'b11;

  function automatic logic is_opcode(input logic [7:0] b);
    return b inside {OpInc, OpDec, OpLeft, OpRight, OpOpen, OpClose, OpOut, OpIn};
  endfunction

endpackage

// File: rtl/bf_bracket_check.sv
// Opcode filter and '['/']' nesting-depth tracker for the code loader.
module bf_bracket_check
  import bf_defs::*;
#(
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             commit_i,
  input  logic [7:0]       byte_i,
  output logic             is_op_o,
  output logic [Width-1:0] depth_o,
  output logic             err_close_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] depth_q, depth_d;

  // commit_i is only raised for bytes actually stored, so ']' never underflows.
  always_comb begin
    depth_d = depth_q;
    if (clear_i) begin
      depth_d = '0;
    end else if (commit_i) begin
      if (byte_i == OpOpen) begin
        depth_d = depth_q + One;
      end else if (byte_i == OpClose) begin
        depth_d = depth_q - One;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  assign is_op_o     = is_opcode(byte_i);
  assign depth_o     = depth_q;
  assign err_close_o = (byte_i == OpClose) && (depth_q == '0);

endmodule

// File: rtl/bf_code_loader.sv
// Streams ASCII BF source into code RAM, filtering comments, checking bracket
// balance and releasing the core once a terminated, balanced program is stored.
module bf_code_loader
  import bf_defs::*;
#(
  parameter int unsigned addrSize = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic [addrSize-1:0] addr_code,
  output logic [7:0]          dataOut_code,
  output logic                writeRq_code,
  output logic                core_run,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [addrSize-1:0] prog_len
);

  localparam logic [addrSize-1:0] LastAddr = '1;
  localparam logic [addrSize-1:0] One      = addrSize'(1);

  state_e              state_q;
  logic [addrSize-1:0] wr_ptr_q;
  logic [addrSize-1:0] addr_q;
  logic [7:0]          data_q;
  logic                wr_q;
  logic                run_q;
  logic                err_q;
  logic [1:0]          err_code_q;

  logic                accept;
  logic                is_op;
  logic                err_close;
  logic                store;
  logic [addrSize-1:0] depth;

  always_comb begin
    accept = byte_ready && byte_valid && !start;
    store  = accept && is_op && (wr_ptr_q != LastAddr) && !err_close;
  end

  bf_bracket_check #(
    .Width(addrSize)
  ) u_bracket_check (
    .clk_i      (clk),
    .rst_i      (reset),
    .clear_i    (start),
    .commit_i   (store),
    .byte_i     (byte_in),
    .is_op_o    (is_op),
    .depth_o    (depth),
    .err_close_o(err_close)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      wr_q  <= 1'b0;
      run_q <= 1'b0;
      if (start) begin
        state_q    <= StLoad;
        wr_ptr_q   <= '0;
        err_q      <= 1'b0;
        err_code_q <= ErrNone;
      end else begin
        unique case (state_q)
          StLoad: begin
            if (accept && byte_in == Term) begin
              // The terminator always lands, even when the load then fails.
              wr_q   <= 1'b1;
              addr_q <= wr_ptr_q;
              data_q <= Term;
              if (depth == '0) begin
                state_q <= StRun;
              end else begin
                state_q    <= StError;
                err_q      <= 1'b1;
                err_code_q <= ErrUnmatchedOpen;
              end
            end else if (accept && is_op) begin
              if (wr_ptr_q == LastAddr) begin
                state_q    <= StError;
                err_q      <= 1'b1;
                err_code_q <= ErrOverflow;
              end else if (err_close) begin
                state_q    <= StError;
                err_q      <= 1'b1;
                err_code_q <= ErrUnmatchedClose;
              end else begin
                wr_q     <= 1'b1;
                addr_q   <= wr_ptr_q;
                data_q   <= byte_in;
                wr_ptr_q <= wr_ptr_q + One;
              end
            end
          end
          // Delayed one cycle so the core starts after the terminator write.
          StRun:   run_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign byte_ready   = (state_q == StLoad);
  assign addr_code    = addr_q;
  assign dataOut_code = data_q;
  assign writeRq_code = wr_q;
  assign core_run     = run_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign prog_len     = wr_ptr_q;

endmodule

// File: tb/tb_bf_code_loader.sv
// Directed bench for bf_code_loader: default-size and 3-bit-address instances,
// expected code-RAM writes checked through a scoreboard queue.
module tb_bf_code_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       sel;  // 0: addrSize=9 instance, 1: addrSize=3 instance

  int checks = 0;
  int errors = 0;

  logic [16:0] sb[$];
  int m_ptr, m_depth, m_last;

  logic       br9, wr9, run9, err9;
  logic [8:0] addr9, len9;
  logic [7:0] data9;
  logic [1:0] ec9;
  logic       br3, wr3, run3, err3;
  logic [2:0] addr3, len3;
  logic [7:0] data3;
  logic [1:0] ec3;

  always #5 clk = ~clk;

  bf_code_loader dut9 (
    .clk         (clk),
    .reset       (reset),
    .start       (start & ~sel),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid & ~sel),
    .byte_ready  (br9),
    .addr_code   (addr9),
    .dataOut_code(data9),
    .writeRq_code(wr9),
    .core_run    (run9),
    .err         (err9),
    .err_code    (ec9),
    .prog_len    (len9)
  );

  bf_code_loader #(
    .addrSize(3)
  ) dut3 (
    .clk         (clk),
    .reset       (reset),
    .start       (start & sel),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid & sel),
    .byte_ready  (br3),
    .addr_code   (addr3),
    .dataOut_code(data3),
    .writeRq_code(wr3),
    .core_run    (run3),
    .err         (err3),
    .err_code    (ec3),
    .prog_len    (len3)
  );

  logic       o_br, o_wr, o_run, o_err;
  logic [8:0] o_addr, o_len;
  logic [7:0] o_data;
  logic [1:0] o_ec;

  assign o_br   = sel ? br3 : br9;
  assign o_wr   = sel ? wr3 : wr9;
  assign o_run  = sel ? run3 : run9;
  assign o_err  = sel ? err3 : err9;
  assign o_addr = sel ? {6'd0, addr3} : addr9;
  assign o_len  = sel ? {6'd0, len3} : len9;
  assign o_data = sel ? data3 : data9;
  assign o_ec   = sel ? ec3 : ec9;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic tb_is_op(input logic [7:0] b);
    return (b == 8'h2B) || (b == 8'h2D) || (b == 8'h3C) || (b == 8'h3E) ||
           (b == 8'h5B) || (b == 8'h5D) || (b == 8'h2E) || (b == 8'h2C);
  endfunction

  // Every write the selected DUT issues must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_wr === 1'b1) begin
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("write_addr", 32'(o_addr), 32'(e[16:8]));
        chk("write_data", 32'(o_data), 32'(e[7:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start   = 1'b1;
    m_ptr   = 0;
    m_depth = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    if (b == 8'h00) begin
      sb.push_back({9'(m_ptr), b});
    end else if (tb_is_op(b) && m_ptr != m_last && !(b == 8'h5D && m_depth == 0)) begin
      sb.push_back({9'(m_ptr), b});
      m_ptr++;
      if (b == 8'h5B) m_depth++;
      if (b == 8'h5D) m_depth--;
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put_byte(s[i]);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(o_br), 32'd0);
    chk({tag, "_wr"}, 32'(o_wr), 32'd0);
    chk({tag, "_run"}, 32'(o_run), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_ec"}, 32'(o_ec), 32'd0);
    chk({tag, "_len"}, 32'(o_len), 32'd0);
    chk({tag, "_addr"}, 32'(o_addr), 32'd0);
    chk({tag, "_data"}, 32'(o_data), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    sel        = 1'b0;
    m_last     = 511;
    m_ptr      = 0;
    m_depth    = 0;
    tick();
    tick();
    chk_reset_state("rst");
    reset = 1'b0;
    tick();

    // Basic program with a balanced loop.
    do_start();
    chk("load_ready", 32'(o_br), 32'd1);
    put_str("+>[-]");
    put_byte(8'h00);
    chk("t1_run_during_term", 32'(o_run), 32'd0);
    chk("t1_len", 32'(o_len), 32'd5);
    tick();
    chk("t1_run", 32'(o_run), 32'd1);
    chk("t1_err", 32'(o_err), 32'd0);
    chk("t1_ready_in_run", 32'(o_br), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Comments are dropped.
    do_start();
    chk("t2_run_cleared", 32'(o_run), 32'd0);
    put_str("a+ b\n-");
    put_byte(8'h00);
    chk("t2_len", 32'(o_len), 32'd2);
    tick();
    chk("t2_run", 32'(o_run), 32'd1);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Unmatched close bracket.
    do_start();
    put_str("]");
    chk("t3_err", 32'(o_err), 32'd1);
    chk("t3_ec", 32'(o_ec), 32'd1);
    chk("t3_run", 32'(o_run), 32'd0);
    repeat (3) tick();
    chk("t3_err_held", 32'(o_err), 32'd1);
    chk("t3_ec_held", 32'(o_ec), 32'd1);
    chk("t3_ready", 32'(o_br), 32'd0);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Unmatched open bracket at terminator.
    do_start();
    chk("t4_err_cleared", 32'(o_err), 32'd0);
    put_str("[[]");
    put_byte(8'h00);
    tick();
    chk("t4_err", 32'(o_err), 32'd1);
    chk("t4_ec", 32'(o_ec), 32'd2);
    chk("t4_run", 32'(o_run), 32'd0);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Overflow on the 3-bit-address instance, then a good reload.
    sel    = 1'b1;
    m_last = 7;
    tick();
    do_start();
    put_str("++++++++");
    tick();
    chk("t5_err", 32'(o_err), 32'd1);
    chk("t5_ec", 32'(o_ec), 32'd3);
    chk("t5_len", 32'(o_len), 32'd7);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    do_start();
    put_str("-");
    put_byte(8'h00);
    tick();
    chk("t5_run", 32'(o_run), 32'd1);
    chk("t5_len2", 32'(o_len), 32'd1);
    chk("t5_err2", 32'(o_err), 32'd0);
    chk("t5_sb_empty2", 32'(sb.size()), 32'd0);

    // Reset mid-load with byte_valid held high.
    sel    = 1'b0;
    m_last = 511;
    tick();
    do_start();
    put_str("+-+");
    byte_in    = 8'h2B;
    byte_valid = 1'b1;
    reset      = 1'b1;
    tick();
    chk_reset_state("t6");
    tick();
    chk("t6_wr_held", 32'(o_wr), 32'd0);
    chk("t6_run_held", 32'(o_run), 32'd0);
    reset      = 1'b0;
    tick();
    chk("t6_wr_after", 32'(o_wr), 32'd0);
    chk("t6_ready_after", 32'(o_br), 32'd0);
    byte_valid = 1'b0;
    tick();
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bf_code_loader.md
BF_CODE_LOADER -- requirements
Module: bf_code_loader

Interface
REQ-001 SHALL have parameter addrSize, default 9, meaning the code RAM address width (2^addrSize bytes).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse that begins a new program load.
REQ-005 SHALL have port byte_in, input, 8 bits: program source byte (ASCII).
REQ-006 SHALL have port byte_valid, input, 1 bit: byte_in is valid this cycle.
REQ-007 SHALL have port byte_ready, output, 1 bit: loader accepts byte_in this cycle.
REQ-008 SHALL have port addr_code, output, addrSize bits: code RAM write address.
REQ-009 SHALL have port dataOut_code, output, 8 bits: code RAM write data.
REQ-010 SHALL have port writeRq_code, output, 1 bit: code RAM write strobe.
REQ-011 SHALL have port core_run, output, 1 bit: drives the core's active-low reset input; high means run.
REQ-012 SHALL have port err, output, 1 bit: load failed.
REQ-013 SHALL have port err_code, output, 2 bits: 01 = unmatched ']', 10 = unmatched '[' at end, 11 = overflow.
REQ-014 SHALL have port prog_len, output, addrSize bits: count of stored instructions, excluding the terminator.

Function
REQ-015 SHALL implement the states IDLE, LOAD, RUN and ERROR.
REQ-016 SHALL go from IDLE, RUN or ERROR to LOAD on start; on entering LOAD it SHALL clear wr_ptr, depth, prog_len and err.
REQ-017 SHALL drive byte_ready = 1 only in LOAD; a byte is accepted in any cycle where byte_valid && byte_ready.
REQ-018 SHALL store an accepted byte only if it is one of + - < > [ ] . , (0x2B 0x2D 0x3C 0x3E 0x5B 0x5D 0x2E 0x2C).
REQ-019 SHALL silently drop any other accepted nonzero byte as a comment; no write, no pointer change.
REQ-020 SHALL, on storing a byte, drive addr_code = wr_ptr, dataOut_code = byte and writeRq_code = 1 in the following cycle, and increment wr_ptr and prog_len.
REQ-021 SHALL drive writeRq_code = 0 in every cycle in which no write is issued.
REQ-022 SHALL increment depth on '['.
REQ-023 SHALL decrement depth on ']' when depth > 0; on ']' with depth == 0 it SHALL write nothing and enter ERROR with err_code 01.
REQ-024 SHALL treat accepted byte 0x00 as the terminator: write 0x00 at wr_ptr, then enter RUN if depth == 0, else ERROR with err_code 10.
REQ-025 SHALL reserve address 2^addrSize-1 for the terminator; a storable byte arriving when wr_ptr == 2^addrSize-1 SHALL cause no write and entry to ERROR with err_code 11.
REQ-026 SHALL keep the depth counter addrSize bits wide; it cannot overflow because of REQ-025.
REQ-027 SHALL drive core_run = 1 only in RUN, registered, starting the cycle after the terminator write.
REQ-028 SHALL hold err = 1 and err_code stable in ERROR until start or reset.
REQ-029 SHALL give start priority in LOAD (restart load, current byte discarded); start in the same cycle as the terminator restarts instead of running.
REQ-030 SHALL leave code RAM contents untouched on restart; they are overwritten as the new load proceeds.

Reset
REQ-031 SHALL, on reset, force state IDLE; byte_ready, writeRq_code, core_run and err to 0; and addr_code, dataOut_code, err_code, prog_len, wr_ptr and depth to 0.
REQ-032 SHALL abort any load when reset occurs mid-load, with no further writes and core_run remaining 0.
REQ-033 SHALL give reset priority over start and byte_valid.

Structure
REQ-034 SHALL place the state encodings, the eight opcode byte constants, the terminator value and the err_code values in the shared bf_defs include, which the core also uses.
REQ-035 SHALL implement the opcode filter and bracket depth tracking in a sub-module bf_bracket_check, reporting is_op, depth and err_close; the FSM and write port stay in the top.

Verification
REQ-036 SHALL verify: start, stream "+>[-]" then 0x00 -> writes 0x2B,0x3E,0x5B,0x2D,0x5D,0x00 at addresses 0..5, prog_len=5, core_run=1 the cycle after the write to address 5.
REQ-037 SHALL verify: stream "a+ b\n-" then 0x00 -> only 0x2B@0, 0x2D@1, 0x00@2 written, prog_len=2.
REQ-038 SHALL verify: stream "]" -> no write, err=1, err_code=01, core_run=0.
REQ-039 SHALL verify: stream "[[]" then 0x00 -> 0x00 written at address 3, err_code=10, core_run=0.
REQ-040 SHALL verify, with addrSize=3: 8 '+' bytes -> addresses 0..6 written, 8th byte gives err_code=11; then start + "-" + 0x00 -> core_run=1, prog_len=1.
REQ-041 SHALL verify: reset asserted after 3 stored bytes with byte_valid held high -> next cycle writeRq_code=0, byte_ready=0, state IDLE, outputs per REQ-031.
